// File: rtl/fetch_stage.sv
// fetch_stage: in-order instruction fetch with redirect kill and decode FIFO; FETCH_PERF_CNT_EN adds perf counters
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [63:0] inst_fetched_out,
  output logic        fetch_valid,
  input  logic        dec_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;
  logic [31:0] pc;
  logic [CW-1:0] outstanding, kill_cnt, fifo_cnt, pend_cnt, fifo_wr, pend_wr;
  logic [63:0] fifo [0:FIFO_DEPTH];
  logic [31:0] pend [0:FIFO_DEPTH];
  logic acc, rsp_match, live, pop;
  assign imem_req_addr = pc;
  always_comb begin
    imem_req_valid = !rst && !redirect_valid && ({1'b0, outstanding} + {1'b0, fifo_cnt} < SW'(FIFO_DEPTH));
    acc = imem_req_valid && imem_req_ready;
    rsp_match = imem_rsp_valid && outstanding != '0;
    live = rsp_match && kill_cnt == '0 && !redirect_valid;
    fetch_valid = !rst && fifo_cnt != '0;
    pop = fetch_valid && dec_ready;
    fifo_wr = fifo_cnt - CW'(pop);
    pend_wr = pend_cnt - CW'(live);
    inst_fetched_out = fetch_valid ? fifo[0] : '0;
  end
  // slot FIFO_DEPTH of each array is a constant-zero shift source
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      outstanding <= '0;
      kill_cnt <= '0;
      fifo_cnt <= '0;
      pend_cnt <= '0;
      for (int i = 0; i <= FIFO_DEPTH; i++) begin
        fifo[i] <= '0;
        pend[i] <= '0;
      end
    end else begin
      pc <= redirect_valid ? {redirect_pc[31:2], 2'b00} : acc ? pc + 32'd4 : pc;
      outstanding <= outstanding + CW'(acc) - CW'(rsp_match);
      kill_cnt <= redirect_valid ? outstanding - CW'(rsp_match) : (rsp_match && kill_cnt != '0) ? kill_cnt - CW'(1) : kill_cnt;
      fifo_cnt <= redirect_valid ? '0 : fifo_cnt + CW'(live) - CW'(pop);
      pend_cnt <= redirect_valid ? '0 : pend_cnt + CW'(acc) - CW'(live);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo[i] <= (live && fifo_wr == CW'(i)) ? {pend[0], imem_rsp_data} : pop ? fifo[i+1] : fifo[i];
        pend[i] <= (acc && pend_wr == CW'(i)) ? pc : live ? pend[i+1] : pend[i];
      end
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_stall <= perf_stall + 32'(!fetch_valid);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized memory/decode/redirect stimulus with a queue scoreboard for fetch_stage
module tb_fetch_stage;
  localparam int DEPTH = 2;
  logic clk = 0, rst = 1;
  logic imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0, redirect_valid = 0, fetch_valid, dec_ready = 0;
  logic [31:0] imem_req_addr, imem_rsp_data = 0, redirect_pc = 0;
  logic [63:0] inst_fetched_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
  int mf = 0, ms = 0;
`endif
  fetch_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_fetched_out(inst_fetched_out), .fetch_valid(fetch_valid), .dec_ready(dec_ready)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );
  typedef struct { logic [31:0] addr; int ep; int due; } mreq_t;
  typedef struct { logic [63:0] ent; int cyc; } exp_t;
  mreq_t mem_q[$];
  exp_t exp_q[$];
  int cyc = 0, epoch = 0, checks = 0, failures = 0;
  int p_rdy = 100, p_dec = 100, p_rsp = 100, p_redir = 0, lat_hi = 1;
  logic force_redir = 0, rsp_real = 0;
  logic [31:0] force_pc = 0, model_pc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, want, cyc);
    end
  endtask
  // monitor: compares DUT outputs against the scoreboard and the fetch-address model
  always @(negedge clk) begin
    int nvis;
    if (rst) begin
      chk("rst_req_valid", 64'(imem_req_valid), 64'(0));
      chk("rst_fetch_valid", 64'(fetch_valid), 64'(0));
      chk("rst_inst", inst_fetched_out, 64'(0));
      model_pc = 32'h0;
`ifdef FETCH_PERF_CNT_EN
      mf = 0;
      ms = 0;
`endif
    end else begin
      nvis = 0;
      foreach (exp_q[i]) if (exp_q[i].cyc < cyc) nvis++;
      chk("fetch_valid", 64'(fetch_valid), 64'(nvis != 0));
      if (nvis != 0) chk("inst", inst_fetched_out, exp_q[0].ent);
      chk("req_valid", 64'(imem_req_valid), 64'(!redirect_valid && (mem_q.size() + int'(rsp_real) + nvis) < DEPTH));
      if (imem_req_valid) chk("req_addr", 64'(imem_req_addr), 64'(model_pc));
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", 64'(perf_fetched), 64'(mf));
      chk("perf_stall", 64'(perf_stall), 64'(ms));
      if (nvis != 0 && dec_ready) mf++;
      if (nvis == 0) ms++;
`endif
      if (fetch_valid && dec_ready && nvis != 0) void'(exp_q.pop_front());
      if (redirect_valid) begin
        exp_q.delete();
        model_pc = redirect_pc & ~32'h3;
      end else if (imem_req_valid && imem_req_ready) begin
        mem_q.push_back('{model_pc, epoch, cyc + int'($urandom_range(lat_hi, 1))});
        model_pc += 32'd4;
      end
    end
  end
  task automatic drive();
    mreq_t r;
    imem_req_ready = $urandom_range(99) < p_rdy;
    dec_ready = $urandom_range(99) < p_dec;
    redirect_valid = force_redir || ($urandom_range(999) < p_redir);
    redirect_pc = force_redir ? force_pc : ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom_range(32'hFFF);
    force_redir = 0;
    imem_rsp_valid = 0;
    rsp_real = 0;
    imem_rsp_data = $urandom;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc && $urandom_range(99) < p_rsp) begin
      r = mem_q.pop_front();
      imem_rsp_valid = 1;
      rsp_real = 1;
      if (!redirect_valid && r.ep == epoch) exp_q.push_back('{{r.addr, imem_rsp_data}, cyc});
    end
    if (redirect_valid) epoch++;
  endtask
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      drive();
    end
  endtask
  // reset, then stray responses with no requests outstanding that must be ignored
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; imem_rsp_valid = 0; rsp_real = 0; redirect_valid = 0; dec_ready = 0; imem_req_ready = 0;
    mem_q.delete(); exp_q.delete(); epoch++;
    @(posedge clk); #1;
    rst = 0;
    repeat (2) begin
      imem_rsp_valid = 1;
      imem_rsp_data = $urandom;
      @(posedge clk); #1;
    end
    imem_rsp_valid = 0;
  endtask
  initial begin
    do_reset();
    run(20);
    p_dec = 0; run(10); p_dec = 100; run(6);
    p_rdy = 0; run(5); p_rdy = 100; run(5);
    lat_hi = 3; run(4);
    force_redir = 1; force_pc = 32'h100; run(1); run(10);
    lat_hi = 1;
    force_redir = 1; force_pc = 32'h203; run(1); run(8);
    force_redir = 1; force_pc = 32'hFFFF_FFF4; run(1);
    force_redir = 1; force_pc = 32'hFFFF_FFF8; run(1); run(10);
    for (int k = 0; k < 8; k++) begin
      p_rdy = $urandom_range(100, 30);
      p_dec = $urandom_range(100, 20);
      p_rsp = $urandom_range(100, 40);
      lat_hi = $urandom_range(4, 1);
      p_redir = $urandom_range(80);
      run(400);
      if (k == 3) do_reset();
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, fetched-instruction buffer entries; legal values 2..4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_req_addr  output  32  word-aligned fetch address.
REQ-008 imem_rsp_valid  input  1  response valid; in order, latency >=1 cycle, cannot be back-pressured.
REQ-009 imem_rsp_data  input  32  instruction word.
REQ-010 redirect_valid  input  1  branch/jump redirect from a later stage.
REQ-011 redirect_pc  input  32  redirect target.
REQ-012 inst_fetched_out  output  inst_fetched_t  fields pc[31:0] and instr[31:0] to decode_stage.
REQ-013 fetch_valid  output  1  inst_fetched_out holds a valid instruction.
REQ-014 dec_ready  input  1  decode_stage accepts inst_fetched_out this cycle.

Function
REQ-015 Request accepted when imem_req_valid && imem_req_ready; PC then advances by 4 next cycle.
REQ-016 imem_req_valid SHALL be 1 only when !rst, !redirect_valid, and (outstanding + fifo_count) < FIFO_DEPTH.
REQ-017 imem_req_addr SHALL equal the PC register; it SHALL stay stable while imem_req_valid=1 and imem_req_ready=0.
REQ-018 Outstanding counter: +1 per accepted request, -1 per imem_rsp_valid; both in one cycle leave it unchanged.
REQ-019 A non-killed response SHALL be written into the FIFO as {pc of its request, imem_rsp_data}; entry visible on outputs the next cycle (1-cycle rsp-to-fetch_valid latency).
REQ-020 Pending-request PCs SHALL be tracked in order, so each FIFO entry carries the PC of its own request.
REQ-021 fetch_valid = FIFO not empty; inst_fetched_out = FIFO head; head popped when fetch_valid && dec_ready.
REQ-022 Push and pop in the same cycle SHALL be supported at any occupancy, including full.
REQ-023 FIFO overflow SHALL be impossible by construction of REQ-016; unmatched response (outstanding=0) SHALL be ignored.
REQ-024 On redirect_valid: PC <= {redirect_pc[31:2],2'b00}; FIFO cleared; kill_cnt <= outstanding minus 1 if imem_rsp_valid in that cycle.
REQ-025 While kill_cnt>0 each response SHALL be dropped and SHALL decrement kill_cnt and outstanding.
REQ-026 Response arriving in the redirect cycle SHALL be dropped.
REQ-027 Redirect and pop in the same cycle: handshake completes (decode keeps that instruction); redirect still clears FIFO.
REQ-028 Back-to-back redirects: the last one sets the PC; kill_cnt recomputed each time per REQ-024.
REQ-029 PC SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000.

Reset
REQ-030 While rst=1: PC=RESET_PC, outstanding=0, kill_cnt=0, FIFO empty, imem_req_valid=0, fetch_valid=0, inst_fetched_out='0.
REQ-031 First cycle after rst falls: imem_req_valid=1, imem_req_addr=RESET_PC.
REQ-032 Reset mid-operation SHALL discard all in-flight and buffered state; responses arriving after reset to pre-reset requests SHALL be ignored per REQ-023.

Configuration
REQ-033 Macro FETCH_PERF_CNT_EN: when defined, outputs perf_fetched[31:0] (count of fetch_valid && dec_ready) and perf_stall[31:0] (cycles with fetch_valid=0 and rst=0); both reset to 0 and wrap at 2^32.
REQ-034 Without FETCH_PERF_CNT_EN those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-035 Reset release, imem_req_ready=1, rsp latency 1, dec_ready=1 -> addrs 0x0,0x4,0x8...; fetch_valid from cycle 3 with pc 0x0, then one instruction per cycle.
REQ-036 dec_ready=0 for 10 cycles -> at most FIFO_DEPTH(2) requests accepted, fetch_valid held, head pc 0x0 stable; dec_ready=1 -> pcs 0x0,0x4 delivered in order, no loss.
REQ-037 Two outstanding requests, redirect_pc=0x100 -> both responses dropped, next request addr 0x100, first fetch_valid entry pc 0x100.
REQ-038 Redirect to 0x203 with simultaneous pop of pc 0x10 -> 0x10 consumed once, FIFO empty next cycle, next request addr 0x200.
REQ-039 imem_req_ready=0 for 5 cycles -> imem_req_addr and imem_req_valid stable, PC not advanced.
REQ-040 With FETCH_PERF_CNT_EN: 8 delivered instructions, 3 empty cycles -> perf_fetched=8, perf_stall=3.
